// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM between the fetch and load/store ports.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module imem_dmem_arbiter #(
  parameter int   AWIDTH     = 12,
  parameter logic RST_PRIO_D = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       i_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_I    = 2'b01,
    TAG_D    = 2'b10
  } rd_tag_e;

  logic    rr_ptr_r;
  rd_tag_e rd_tag_r;
  logic    conflict_s;
  logic    i_gnt_s;
  logic    d_gnt_s;

  // Grant selection: rr_ptr_r only matters when both ports request.
  always_comb begin
    i_gnt_s    = 1'b0;
    d_gnt_s    = 1'b0;
    conflict_s = i_req & d_req;
    if (rst) begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else begin
      case ({i_req, d_req})
        2'b11: begin
          d_gnt_s = rr_ptr_r;
          i_gnt_s = ~rr_ptr_r;
        end
        2'b10:   i_gnt_s = 1'b1;
        2'b01:   d_gnt_s = 1'b1;
        default: begin
          i_gnt_s = 1'b0;
          d_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // Memory command mux: the winner drives the RAM, an idle bus is all zeros.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 4'h0;
    mem_addr = {AWIDTH{1'b0}};
    mem_din  = 32'h0000_0000;
    case ({i_gnt_s, d_gnt_s})
      2'b10: begin
        mem_en   = 1'b1;
        mem_addr = i_addr;
      end
      2'b01: begin
        mem_en   = 1'b1;
        mem_we   = d_we;
        mem_addr = d_addr;
        mem_din  = d_wdata;
      end
      default: begin
        mem_en   = 1'b0;
        mem_we   = 4'h0;
        mem_addr = {AWIDTH{1'b0}};
        mem_din  = 32'h0000_0000;
      end
    endcase
  end

  // Priority pointer and read-return tag; the pointer favours the loser of the last conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= RST_PRIO_D;
      rd_tag_r <= TAG_NONE;
    end else begin
      if (conflict_s) begin
        rr_ptr_r <= i_gnt_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (i_gnt_s) begin
        rd_tag_r <= TAG_I;
      end else if (d_gnt_s && (d_we == 4'h0)) begin
        rd_tag_r <= TAG_D;
      end else begin
        rd_tag_r <= TAG_NONE;
      end
    end
  end

  assign i_gnt    = i_gnt_s;
  assign d_gnt    = d_gnt_s;
  assign i_rvalid = (rd_tag_r == TAG_I);
  assign d_rvalid = (rd_tag_r == TAG_D);
  assign i_rdata  = mem_dout;
  assign d_rdata  = mem_dout;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_r;
  logic [31:0] i_stall_cnt_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

  // Saturating event counters for conflicts and fetch stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_r <= 32'h0000_0000;
      i_stall_cnt_r  <= 32'h0000_0000;
    end else begin
      if (conflict_s) begin
        conflict_cnt_r <= sat_inc(conflict_cnt_r);
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
      if (i_req && !i_gnt_s) begin
        i_stall_cnt_r <= sat_inc(i_stall_cnt_r);
      end else begin
        i_stall_cnt_r <= i_stall_cnt_r;
      end
    end
  end

  assign conflict_cnt = conflict_cnt_r;
  assign i_stall_cnt  = i_stall_cnt_r;
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Randomized and directed bench for imem_dmem_arbiter against a transaction-level model.
// Counter checks are compiled in when ARB_PERF_CNT_EN is defined.
module tb_imem_dmem_arbiter;
  localparam int   AW     = 12;
  localparam logic PRIO_D = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_we;
  logic [31:0]   d_wdata;
  logic          i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en;
  logic [31:0]   i_rdata, d_rdata, mem_din, mem_dout;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   conflict_cnt, i_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  imem_dmem_arbiter #(.AWIDTH(AW), .RST_PRIO_D(PRIO_D)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
`ifdef ARB_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt), .i_stall_cnt(i_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM macro: synchronous read, byte-enabled write.
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end
      mem_dout <= ram[mem_addr];
    end
  end

  // Reference model state: memory image, who wins the next conflict, pending returns.
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic        ref_prio_d;
  logic        exp_iv, exp_dv;
  logic [31:0] exp_idata, exp_ddata;
  logic [31:0] exp_conf, exp_stall;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: verify last cycle's returns, apply inputs, verify grant/bus, advance model.
  task automatic run_cycle(input logic r, input logic ir, input logic [AW-1:0] ia,
                           input logic dr, input logic [3:0] dwe, input logic [AW-1:0] da,
                           input logic [31:0] dwd);
    int winner;  // 0 none, 1 fetch, 2 data
    @(negedge clk);
    check_val("i_rvalid", {31'd0, i_rvalid}, {31'd0, exp_iv});
    check_val("d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_dv});
    if (exp_iv) check_val("i_rdata", i_rdata, exp_idata);
    if (exp_dv) check_val("d_rdata", d_rdata, exp_ddata);
`ifdef ARB_PERF_CNT_EN
    check_val("conflict_cnt", conflict_cnt, exp_conf);
    check_val("i_stall_cnt", i_stall_cnt, exp_stall);
`endif
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    #1;
    if (r) winner = 0;
    else if (ir && dr) winner = ref_prio_d ? 2 : 1;
    else if (ir) winner = 1;
    else if (dr) winner = 2;
    else winner = 0;
    check_val("i_gnt", {31'd0, i_gnt}, (winner == 1) ? 32'd1 : 32'd0);
    check_val("d_gnt", {31'd0, d_gnt}, (winner == 2) ? 32'd1 : 32'd0);
    check_val("mem_en", {31'd0, mem_en}, (winner != 0) ? 32'd1 : 32'd0);
    check_val("mem_we", {28'd0, mem_we}, (winner == 2) ? {28'd0, dwe} : 32'd0);
    check_val("mem_addr", {20'd0, mem_addr},
              (winner == 1) ? {20'd0, ia} : (winner == 2) ? {20'd0, da} : 32'd0);
    check_val("mem_din", mem_din, (winner == 2) ? dwd : 32'd0);
    exp_iv = (winner == 1);
    exp_dv = (winner == 2) && (dwe == 4'h0);
    if (winner == 1) exp_idata = ref_mem[ia];
    if (winner == 2) begin
      exp_ddata = ref_mem[da];
      for (int b = 0; b < 4; b++) begin
        if (dwe[b]) ref_mem[da][8*b +: 8] = dwd[8*b +: 8];
      end
    end
    if (r) begin
      ref_prio_d = PRIO_D;
      exp_conf   = 32'd0;
      exp_stall  = 32'd0;
    end else begin
      if (ir && dr) begin
        ref_prio_d = (winner == 1);
        if (exp_conf != 32'hFFFF_FFFF) exp_conf = exp_conf + 32'd1;
      end
      if (ir && winner != 1 && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
    end
  endtask

  task automatic idle(input logic r);
    run_cycle(r, 1'b0, '0, 1'b0, 4'h0, '0, 32'd0);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      ram[a]     = a * 4 + 1;
      ref_mem[a] = a * 4 + 1;
    end
    ram[5]     = 32'h1122_3344;
    ref_mem[5] = 32'h1122_3344;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0; d_we = 4'h0; d_wdata = 32'd0;
    ref_prio_d = PRIO_D; exp_iv = 1'b0; exp_dv = 1'b0; exp_idata = 32'd0; exp_ddata = 32'd0;
    exp_conf = 32'd0; exp_stall = 32'd0;

    // Reset with both ports requesting: no grants, idle bus.
    run_cycle(1'b1, 1'b1, 12'd7, 1'b1, 4'h0, 12'd9, 32'd0);
    run_cycle(1'b1, 1'b1, 12'd7, 1'b1, 4'h0, 12'd9, 32'd0);

    // Fetch-only stream.
    for (int a = 0; a < 4; a++) run_cycle(1'b0, 1'b1, a[AW-1:0], 1'b0, 4'h0, '0, 32'd0);
    idle(1'b0);
    check_val("fetch3_data", i_rdata, 32'd13);

    // Store then load.
    run_cycle(1'b0, 1'b0, '0, 1'b1, 4'hF, 12'd10, 32'hDEAD_BEEF);
    run_cycle(1'b0, 1'b0, '0, 1'b1, 4'h0, 12'd10, 32'd0);
    idle(1'b0);
    check_val("load_deadbeef", d_rdata, 32'hDEAD_BEEF);

    // Conflicts straight after reset alternate D, I, D, I.
    idle(1'b1);
    for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b1, 12'd1, 1'b1, 4'h0, 12'd2, 32'd0);
    idle(1'b0);

    // Byte-lane write merges into the existing word.
    run_cycle(1'b0, 1'b0, '0, 1'b1, 4'b0010, 12'd5, 32'h0000_AA00);
    run_cycle(1'b0, 1'b0, '0, 1'b1, 4'h0, 12'd5, 32'd0);
    idle(1'b0);
    check_val("byte_merge", d_rdata, 32'h1122_AA44);

    // Reset in the cycle after a data read grant, then a conflict favours data again.
    run_cycle(1'b0, 1'b1, 12'd3, 1'b1, 4'h0, 12'd4, 32'd0);
    run_cycle(1'b0, 1'b0, '0, 1'b1, 4'h0, 12'd6, 32'd0);
    idle(1'b1);
    run_cycle(1'b0, 1'b1, 12'd3, 1'b1, 4'h0, 12'd4, 32'd0);
    idle(1'b0);

`ifdef ARB_PERF_CNT_EN
    idle(1'b1);
    for (int k = 0; k < 6; k++) run_cycle(1'b0, 1'b1, 12'd1, 1'b1, 4'h0, 12'd2, 32'd0);
    idle(1'b0);
    check_val("conf_six", conflict_cnt, 32'd6);
    check_val("stall_three", i_stall_cnt, 32'd3);
    force dut.conflict_cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_cnt_r;
    exp_conf = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b1, 12'd1, 1'b1, 4'h0, 12'd2, 32'd0);
    idle(1'b0);
    check_val("conf_saturate", conflict_cnt, 32'hFFFF_FFFF);
`endif

    // Random traffic over a small address window so reads hit recent writes.
    for (int n = 0; n < 2000; n++) begin
      logic        rr, ir, dr;
      logic [3:0]  we;
      rr = ($urandom_range(63) == 0);
      ir = $urandom_range(1);
      dr = $urandom_range(1);
      we = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
      run_cycle(rr, ir, AW'($urandom_range(31)), dr, we, AW'($urandom_range(31)), $urandom);
    end
    idle(1'b0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port, synchronous-read 32-bit BIOS/data RAM between the CPU instruction-fetch port and the CPU load/store port.
- Sits between the CPU pipeline and the memory macro.
- Arbitrates cycle-by-cycle using a round-robin policy that only advances on conflicts.
- Returns read data one cycle after grant, tagged to the winning port, so the pipeline stalls only the losing port.

Parameters:
- AWIDTH, 12, word-address width of the shared RAM (4096 words).
- RST_PRIO_D, 1, round-robin pointer value after reset (1 = data port wins the first conflict).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request (read only).
- i_addr  in  AWIDTH  fetch word address.
- i_gnt  out  1  fetch accepted this cycle (combinational).
- i_rvalid  out  1  fetch read data valid (registered).
- i_rdata  out  32  fetch read data.
- d_req  in  1  load/store request.
- d_we  in  4  byte write enables; 0 = read.
- d_addr  in  AWIDTH  data word address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data access accepted this cycle (combinational).
- d_rvalid  out  1  load data valid (registered; never set for writes).
- d_rdata  out  32  load data.
- mem_en  out  1  RAM enable.
- mem_we  out  4  RAM byte write enables.
- mem_addr  out  AWIDTH  RAM address.
- mem_din  out  32  RAM write data.
- mem_dout  in  32  RAM read data, valid one cycle after mem_en.

Behaviour:
- Grant logic (combinational from req and rr_ptr):
  - Only i_req: i_gnt=1.
  - Only d_req: d_gnt=1.
  - Both: rr_ptr=1 grants data, rr_ptr=0 grants fetch.
  - At most one gnt is high in any cycle.
- Memory issue, same cycle as grant:
  - mem_en = i_gnt | d_gnt.
  - mem_addr/mem_we/mem_din are taken from the winner; mem_we=0 when fetch wins.
  - When no grant: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- rr_ptr update:
  - Updates only on a conflict cycle (both req high).
  - New value is 0 if data won, 1 if fetch won.
  - Non-conflict cycles leave rr_ptr unchanged.
- Read return:
  - Registered rd_tag (2'b00 none, 01 fetch, 10 data) is captured at the grant edge.
  - Next cycle: i_rvalid = (rd_tag==01) and d_rvalid = (rd_tag==10).
  - A granted write sets rd_tag=00.
  - i_rdata and d_rdata both drive mem_dout; consumers qualify with rvalid.
- Back-to-back: a new grant may be issued in the same cycle as the previous read's rvalid. Throughput is 1 access/cycle.
- Requester contract:
  - A requester holds req and its address/data stable until it sees gnt.
  - The arbiter does not register requests.
  - Dropping req before gnt is legal and simply withdraws the request.
- Reset (synchronous):
  - rr_ptr=RST_PRIO_D, rd_tag=00.
  - i_rvalid=0, d_rvalid=0, mem_en=0.
  - While rst is high: both gnt=0 and mem_en=0, regardless of requests.
  - Reset mid-operation discards any pending rvalid; no rvalid is produced in the cycle after reset deasserts unless a grant occurred in the first non-reset cycle.
- Address out of range is not possible (width-limited); upper CPU address bits are decoded upstream.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, two extra 32-bit output ports are added:
  - conflict_cnt: counts cycles with both requests high.
  - i_stall_cnt: counts cycles with i_req=1 and i_gnt=0.
- Both counters reset to 0, saturate at 32'hFFFF_FFFF and hold (no wrap).
- When not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Fetch only: i_req=1 for 4 cycles at addresses 0..3 with RAM preloaded as addr×4+1 → i_gnt every cycle; i_rvalid on cycles 2..5 with i_rdata=1,5,9,13; d_rvalid stays 0.
- Data store then load: d_we=4'hF, d_addr=10, d_wdata=32'hDEADBEEF; next cycle d_we=0, d_addr=10 → store produces no d_rvalid; the load returns d_rdata=32'hDEADBEEF with d_rvalid one cycle after its grant.
- Conflict round-robin: after reset both req held high for 4 cycles → grant sequence D,I,D,I; rr_ptr alternates; i_rvalid/d_rvalid follow the same sequence one cycle later.
- Byte write: mem word 5 = 32'h11223344, store d_we=4'b0010 with d_wdata=32'h0000AA00, then read → d_rdata=32'h1122AA44.
- Reset mid-read: grant a data read, assert rst on the next edge → d_rvalid=0 the following cycle; rr_ptr back to RST_PRIO_D; first post-reset conflict grants data.
- With ARB_PERF_CNT_EN: 6 conflict cycles → conflict_cnt=6 and i_stall_cnt=3; preload conflict_cnt to FFFF_FFFE via force, then 3 conflicts → conflict_cnt=FFFF_FFFF.
